// File: rtl/uni_shft_reg_n_if.sv
// Bus bundle for the universal shift register: mode/burst controls in,
// register contents and burst status out.
interface uni_shft_reg_n_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             ser_inl;
  logic             ser_inr;
  logic [WIDTH-1:0] par_in;
  logic [2:0]       sel;
  logic             start;
  logic             dir;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] par_out;
  logic             ser_outr;
  logic             ser_outl;
  logic             busy;
  logic             done;

  modport master (
    output ser_inl, ser_inr, par_in, sel, start, dir, cnt,
    input  par_out, ser_outr, ser_outl, busy, done
  );

  modport slave (
    input  ser_inl, ser_inr, par_in, sel, start, dir, cnt,
    output par_out, ser_outr, ser_outl, busy, done
  );
endinterface

// File: rtl/uni_shft_reg_n.sv
// Universal N-bit shift register with single-step modes while idle and a
// counted burst-shift mode that reports busy/done.
module uni_shft_reg_n #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  uni_shft_reg_n_if.slave   bus
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;

  logic             last_shift;
  assign last_shift = (rem_q == CNT_W'(1));

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic
  // NOTE: every combinational output gets a default first, so no path
  // through the block can leave a variable unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start && (bus.cnt != '0)) state_d = BURST;
      BURST:   if (last_shift)                   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and counter next values; start outranks sel while idle
  always_comb begin
    data_d = data_q;
    rem_d  = rem_q;
    dir_d  = dir_q;
    done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.cnt != '0) begin
            rem_d = bus.cnt;
            dir_d = bus.dir;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          case (bus.sel)
            3'd1:    data_d = {bus.ser_inr, data_q[WIDTH-1:1]};
            3'd2:    data_d = {data_q[WIDTH-2:0], bus.ser_inl};
            3'd3:    data_d = bus.par_in;
            3'd4:    data_d = {data_q[0], data_q[WIDTH-1:1]};
            3'd5:    data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
            3'd6:    data_d = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
            default: data_d = data_q;
          endcase
        end
      end
      BURST: begin
        if (dir_q) data_d = {data_q[WIDTH-2:0], bus.ser_inl};
        else       data_d = {bus.ser_inr, data_q[WIDTH-1:1]};
        rem_d = rem_q - CNT_W'(1);
        if (last_shift) done_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Output logic
  always_comb begin
    bus.par_out  = data_q;
    bus.ser_outr = data_q[0];
    bus.ser_outl = data_q[WIDTH-1];
    bus.busy     = (state_q == BURST);
    bus.done     = done_q;
  end

endmodule

// File: tb/tb_uni_shft_reg_n.sv
// Directed self-checking bench for uni_shft_reg_n (WIDTH=8, CNT_W=4).
module tb_uni_shft_reg_n;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   busy_cycles;

  uni_shft_reg_n_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  uni_shft_reg_n #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [WIDTH-1:0] v);
    bus.sel    = 3'd3;
    bus.par_in = v;
    tick();
    bus.sel    = 3'd0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.ser_inl = 1'b0;
    bus.ser_inr = 1'b0;
    bus.par_in  = '0;
    bus.sel     = 3'd0;
    bus.start   = 1'b0;
    bus.dir     = 1'b0;
    bus.cnt     = '0;

    // Reset state
    #12;
    check("rst_par_out", 32'(bus.par_out), 32'h00);
    check("rst_busy",    32'(bus.busy),    32'h0);
    check("rst_done",    32'(bus.done),    32'h0);
    tick();
    rst = 1'b0;

    // Parallel load then hold
    load(8'hA5);
    check("load_a5", 32'(bus.par_out), 32'hA5);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_a5", 32'(bus.par_out), 32'hA5);
    end
    check("ser_outr", 32'(bus.ser_outr), 32'h1);
    check("ser_outl", 32'(bus.ser_outl), 32'h1);

    // Right shift in ones, then left shift in zeros
    load(8'h00);
    bus.sel = 3'd1; bus.ser_inr = 1'b1;
    repeat (4) tick();
    check("shr_f0", 32'(bus.par_out), 32'hF0);
    bus.sel = 3'd2; bus.ser_inl = 1'b0;
    repeat (2) tick();
    check("shl_c0", 32'(bus.par_out), 32'hC0);
    bus.ser_inr = 1'b0;

    // Rotates and arithmetic shift
    load(8'h81); bus.sel = 3'd4; tick();
    check("ror_c0", 32'(bus.par_out), 32'hC0);
    load(8'h81); bus.sel = 3'd5; tick();
    check("rol_03", 32'(bus.par_out), 32'h03);
    load(8'h81); bus.sel = 3'd6; tick();
    check("asr_c0", 32'(bus.par_out), 32'hC0);

    // Left burst of 3 with sel toggled throughout
    load(8'h01);
    bus.start = 1'b1; bus.dir = 1'b1; bus.cnt = 4'd3; bus.ser_inl = 1'b0;
    tick();
    bus.start = 1'b0; bus.sel = 3'd3; bus.par_in = 8'hFF;
    check("b_cap_busy", 32'(bus.busy),    32'h1);
    check("b_cap_par",  32'(bus.par_out), 32'h01);
    tick();
    bus.sel = 3'd2;
    check("b1_par",  32'(bus.par_out), 32'h02);
    check("b1_busy", 32'(bus.busy),    32'h1);
    tick();
    bus.sel = 3'd0;
    check("b2_par",  32'(bus.par_out), 32'h04);
    check("b2_busy", 32'(bus.busy),    32'h1);
    tick();
    check("b3_par",  32'(bus.par_out), 32'h08);
    check("b3_busy", 32'(bus.busy),    32'h0);
    check("b3_done", 32'(bus.done),    32'h1);

    // Start accepted on the done cycle: right burst of 2, ser_inr=1
    bus.start = 1'b1; bus.dir = 1'b0; bus.cnt = 4'd2; bus.ser_inr = 1'b1;
    tick();
    check("r_cap_busy", 32'(bus.busy), 32'h1);
    check("r_cap_done", 32'(bus.done), 32'h0);
    check("r_cap_par",  32'(bus.par_out), 32'h08);
    // Start during the burst must be dropped
    bus.dir = 1'b1; bus.cnt = 4'd1;
    tick();
    bus.start = 1'b0;
    check("r1_par", 32'(bus.par_out), 32'h84);
    tick();
    check("r2_par",  32'(bus.par_out), 32'hC2);
    check("r2_busy", 32'(bus.busy),    32'h0);
    check("r2_done", 32'(bus.done),    32'h1);
    tick();
    check("r_noq_busy", 32'(bus.busy),    32'h0);
    check("r_noq_done", 32'(bus.done),    32'h0);
    check("r_noq_par",  32'(bus.par_out), 32'hC2);

    // Zero-count start: done pulse only, start outranks sel=load
    bus.start = 1'b1; bus.cnt = 4'd0; bus.sel = 3'd3; bus.par_in = 8'h55;
    tick();
    bus.start = 1'b0; bus.sel = 3'd0;
    check("z_busy", 32'(bus.busy),    32'h0);
    check("z_done", 32'(bus.done),    32'h1);
    check("z_par",  32'(bus.par_out), 32'hC2);
    tick();
    check("z_done_end", 32'(bus.done),    32'h0);
    check("z_par_end",  32'(bus.par_out), 32'hC2);

    // Asynchronous reset in the 2nd cycle of a 5-shift burst
    load(8'h01);
    bus.start = 1'b1; bus.dir = 1'b1; bus.cnt = 4'd5; bus.ser_inl = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check("m1_par", 32'(bus.par_out), 32'h03);
    #2;
    rst = 1'b1;
    #1;
    check("m_rst_par",  32'(bus.par_out), 32'h00);
    check("m_rst_busy", 32'(bus.busy),    32'h0);
    check("m_rst_done", 32'(bus.done),    32'h0);
    bus.start = 1'b1; bus.cnt = 4'd2;
    tick();
    check("m_rst_ign", 32'(bus.busy), 32'h0);
    bus.start = 1'b0;
    rst = 1'b0;
    repeat (6) begin
      tick();
      check("m_no_done", 32'(bus.done), 32'h0);
    end
    check("m_post_par", 32'(bus.par_out), 32'h00);
    bus.start = 1'b1; bus.dir = 1'b0; bus.cnt = 4'd1; bus.ser_inr = 1'b1;
    tick();
    bus.start = 1'b0;
    check("n_busy", 32'(bus.busy), 32'h1);
    tick();
    check("n_par",  32'(bus.par_out), 32'h80);
    check("n_done", 32'(bus.done),    32'h1);

    // Count larger than WIDTH: 10 left shifts of ones from 8'h80
    bus.start = 1'b1; bus.dir = 1'b1; bus.cnt = 4'd10; bus.ser_inl = 1'b1;
    tick();
    bus.start = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 20 && bus.busy; i++) begin
      busy_cycles++;
      tick();
    end
    check("big_busy_cycles", 32'(busy_cycles), 32'd10);
    check("big_par",  32'(bus.par_out), 32'hFF);
    check("big_done", 32'(bus.done),    32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uni_shft_reg_n.md
UNI_SHFT_REG_N -- requirements
Module: uni_shft_reg_n

Interface
REQ-001: Parameter WIDTH, default 8, register width in bits; legal values are 2 or more.
REQ-002: Parameter CNT_W, default 4, width of the burst shift-count input.
REQ-003: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004: rst  input  1  reset; asynchronous and active-high.
REQ-005: ser_inl  input  1  serial bit entering bit 0 on left shifts.
REQ-006: ser_inr  input  1  serial bit entering bit WIDTH-1 on right shifts.
REQ-007: par_in  input  WIDTH  parallel load data.
REQ-008: sel  input  3  mode select, used only while idle.
REQ-009: start  input  1  burst request, sampled while idle.
REQ-010: dir  input  1  burst direction, sampled with start: 0 = right, 1 = left.
REQ-011: cnt  input  CNT_W  burst shift count, sampled with start.
REQ-012: par_out  output  WIDTH  register contents.
REQ-013: ser_outr  output  1  equals par_out[0], combinational.
REQ-014: ser_outl  output  1  equals par_out[WIDTH-1], combinational.
REQ-015: busy  output  1  high while a burst is in progress.
REQ-016: done  output  1  one-cycle pulse marking burst completion.

Function
REQ-017: The block SHALL have two states, IDLE and BURST.
REQ-018: In IDLE with start=0, the register SHALL update per sel on each clock edge:
- 0: hold.
- 1: shift right; q <= {ser_inr, q[WIDTH-1:1]}.
- 2: shift left; q <= {q[WIDTH-2:0], ser_inl}.
- 3: parallel load of par_in.
- 4: rotate right; q <= {q[0], q[WIDTH-1:1]}.
- 5: rotate left; q <= {q[WIDTH-2:0], q[WIDTH-1]}.
- 6: arithmetic shift right; q <= {q[WIDTH-1], q[WIDTH-1:1]}.
- 7: hold (reserved).
REQ-019: Start handling in IDLE:
- start=1 with cnt!=0: capture dir and cnt, load remaining counter with cnt, leave the register unchanged that cycle, move to BURST, and assert busy from the next cycle.
- start=1 with cnt=0: stay in IDLE, leave the register unchanged, and pulse done for one cycle on the next cycle; busy stays low.
- start has priority over sel in IDLE.
REQ-020: In BURST, each clock SHALL perform one shift in the captured direction and decrement the remaining counter:
- right shifts take ser_inr.
- left shifts take ser_inl.
- serial inputs are sampled live, each cycle.
REQ-021: When the shift that brings the remaining counter from 1 to 0 occurs, the block SHALL return to IDLE, drop busy, and pulse done high for exactly the following cycle.
REQ-022: A burst of N shifts SHALL keep busy high for exactly N cycles.
REQ-023: While in BURST, sel, start, dir, cnt and par_in SHALL be ignored; a start during BURST is dropped, not queued.
REQ-024: A start on the same cycle done is high SHALL be accepted, since the block is already in IDLE.
REQ-025: A cnt value larger than WIDTH SHALL be honoured literally: an all-serial-input fill, then continued shifting.
REQ-026: ser_outr and ser_outl SHALL reflect the current register with zero latency.

Reset
REQ-027: Asserting rst at any time, including mid-burst, SHALL immediately force the following, without waiting for a clock edge:
- par_out = 0, busy = 0, done = 0.
- remaining counter = 0.
- state = IDLE.
REQ-028: While rst is high, start SHALL be ignored; the first accepted operation is on the first clock edge after rst deasserts.

Verification (WIDTH=8)
REQ-029: Parallel load, then hold: sel=3, par_in=8'hA5 for 1 clock, then sel=0 for 3 clocks -> par_out=8'hA5 throughout; ser_outr=1; ser_outl=1.
REQ-030: Right shift, then left shift from 8'h00:
- sel=1 with ser_inr=1 for 4 clocks -> par_out=8'hF0.
- then sel=2 with ser_inl=0 for 2 clocks -> par_out=8'hC0.
REQ-031: Rotate and arithmetic shift, each starting from a load of 8'h81:
- sel=4 for 1 clock -> 8'hC0.
- sel=5 for 1 clock -> 8'h03.
- sel=6 for 1 clock -> 8'hC0.
REQ-032: Burst after a load of 8'h01: start=1, dir=1, cnt=3, ser_inl=0 ->
- busy high for exactly 3 cycles.
- par_out=8'h08.
- done high for 1 cycle after busy falls.
- sel toggled during the burst has no effect.
REQ-033: Zero-count burst: start=1, cnt=0 -> busy stays 0; done pulses once on the next cycle; par_out unchanged.
REQ-034: Reset mid-burst: rst asserted asynchronously during the 2nd cycle of a cnt=5 burst ->
- par_out=0, busy=0, done=0 without waiting for a clock edge.
- no done pulse after release.
- a new start is accepted normally afterwards.
